// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands and control with freeze, flush and valid gating.
// Optional saturating bubble/stall counters are built when ID_EX_PERF_EN is defined.
module id_ex_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_val_rn,
   input  logic [DATA_W-1:0] id_val_rm,
   input  logic              id_imm,
   input  logic [11:0]       id_shift_operand,
   input  logic [23:0]       id_signed_imm_24,
   input  logic [3:0]        id_dest,
   input  logic [3:0]        id_src1,
   input  logic [3:0]        id_src2,
   input  logic [3:0]        id_exe_cmd,
   input  logic              id_wb_en,
   input  logic              id_mem_r_en,
   input  logic              id_mem_w_en,
   input  logic              id_b,
   input  logic              id_s,
   input  logic [3:0]        id_status,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_val_rn,
   output logic [DATA_W-1:0] ex_val_rm,
   output logic              ex_imm,
   output logic [11:0]       ex_shift_operand,
   output logic [23:0]       ex_signed_imm_24,
   output logic [3:0]        ex_dest,
   output logic [3:0]        ex_src1,
   output logic [3:0]        ex_src2,
   output logic [3:0]        ex_exe_cmd,
   output logic              ex_wb_en,
   output logic              ex_mem_r_en,
   output logic              ex_mem_w_en,
   output logic              ex_b,
   output logic              ex_s,
   output logic [3:0]        ex_status,
   output logic              ex_mem_access,
   output logic [CNT_W-1:0]  bubble_count,
   output logic [CNT_W-1:0]  stall_count
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         // Reset and flush both produce an all-zero bubble.
         ex_valid         <= 1'b0;
         ex_pc            <= '0;
         ex_val_rn        <= '0;
         ex_val_rm        <= '0;
         ex_imm           <= 1'b0;
         ex_shift_operand <= '0;
         ex_signed_imm_24 <= '0;
         ex_dest          <= '0;
         ex_src1          <= '0;
         ex_src2          <= '0;
         ex_exe_cmd       <= '0;
         ex_wb_en         <= 1'b0;
         ex_mem_r_en      <= 1'b0;
         ex_mem_w_en      <= 1'b0;
         ex_b             <= 1'b0;
         ex_s             <= 1'b0;
         ex_status        <= '0;
         ex_mem_access    <= 1'b0;
      end else if (!freeze) begin
         ex_valid         <= id_valid;
         ex_pc            <= id_pc;
         ex_val_rn        <= id_val_rn;
         ex_val_rm        <= id_val_rm;
         ex_imm           <= id_imm;
         ex_shift_operand <= id_shift_operand;
         ex_signed_imm_24 <= id_signed_imm_24;
         ex_dest          <= id_dest;
         ex_src1          <= id_src1;
         ex_src2          <= id_src2;
         ex_exe_cmd       <= id_exe_cmd;
         // Control is gated by valid so a non-instruction can never write state.
         ex_wb_en         <= id_valid & id_wb_en;
         ex_mem_r_en      <= id_valid & id_mem_r_en;
         ex_mem_w_en      <= id_valid & id_mem_w_en;
         ex_b             <= id_valid & id_b;
         ex_s             <= id_valid & id_s;
         ex_status        <= id_status;
         ex_mem_access    <= id_valid & (id_mem_r_en | id_mem_w_en);
      end
   end

`ifdef ID_EX_PERF_EN
   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_q <= '0;
         stall_q  <= '0;
      end else begin
         if ((flush || (!freeze && !id_valid)) && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_q <= bubble_q + CNT_W'(1);
         end
         if (freeze && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
         end
      end
   end

   assign bubble_count = bubble_q;
   assign stall_count  = stall_q;
`else
   assign bubble_count = '0;
   assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Table-driven bench for id_ex_stage_reg, plus hand-written latency and counter saturation sequences.
module tb_id_ex_stage_reg;

   localparam int unsigned CW = 4;
`ifdef ID_EX_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] val_rn;
      logic [31:0] val_rm;
      logic        imm;
      logic [11:0] shift_operand;
      logic [23:0] signed_imm_24;
      logic [3:0]  dest;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic [3:0]  exe_cmd;
      logic        wb_en;
      logic        mem_r_en;
      logic        mem_w_en;
      logic        b;
      logic        s;
      logic [3:0]  status;
   } fields_t;

   typedef struct {
      logic    rst;
      logic    freeze;
      logic    flush;
      fields_t in;
      fields_t exp;
      logic    exp_ma;
      int      exp_bub;
      int      exp_stl;
   } vec_t;

   localparam fields_t ZERO = '0;
   localparam fields_t ALL1 = '1;
   localparam fields_t A = '{valid: 1'b1, pc: 32'h0000_1004, val_rn: 32'h1234_5678,
      val_rm: 32'h8000_0001, imm: 1'b0, shift_operand: 12'h0C5, signed_imm_24: 24'hABCDEF,
      dest: 4'h3, src1: 4'h1, src2: 4'h2, exe_cmd: 4'h2, wb_en: 1'b1, mem_r_en: 1'b1,
      mem_w_en: 1'b0, b: 1'b0, s: 1'b0, status: 4'hA};
   localparam fields_t B = '{valid: 1'b1, pc: 32'h0000_2008, val_rn: 32'hDEAD_BEEF,
      val_rm: 32'h0F0F_0F0F, imm: 1'b1, shift_operand: 12'hFFF, signed_imm_24: 24'h800000,
      dest: 4'hF, src1: 4'h7, src2: 4'h8, exe_cmd: 4'h9, wb_en: 1'b0, mem_r_en: 1'b0,
      mem_w_en: 1'b1, b: 1'b1, s: 1'b1, status: 4'h5};
   localparam fields_t C = '{valid: 1'b1, pc: 32'h0000_3010, val_rn: 32'h0000_0055,
      val_rm: 32'hFFFF_FFFE, imm: 1'b1, shift_operand: 12'h801, signed_imm_24: 24'h7FFFFF,
      dest: 4'h9, src1: 4'hC, src2: 4'hD, exe_cmd: 4'h4, wb_en: 1'b1, mem_r_en: 1'b0,
      mem_w_en: 1'b0, b: 1'b0, s: 1'b1, status: 4'h3};
   localparam fields_t INV = '{valid: 1'b0, pc: 32'h0000_300C, val_rn: 32'h0000_0001,
      val_rm: 32'h0000_0002, imm: 1'b1, shift_operand: 12'h123, signed_imm_24: 24'h000001,
      dest: 4'hA, src1: 4'h4, src2: 4'h5, exe_cmd: 4'h6, wb_en: 1'b1, mem_r_en: 1'b0,
      mem_w_en: 1'b1, b: 1'b1, s: 1'b1, status: 4'hC};
   localparam fields_t INV_EXP = '{valid: 1'b0, pc: 32'h0000_300C, val_rn: 32'h0000_0001,
      val_rm: 32'h0000_0002, imm: 1'b1, shift_operand: 12'h123, signed_imm_24: 24'h000001,
      dest: 4'hA, src1: 4'h4, src2: 4'h5, exe_cmd: 4'h6, wb_en: 1'b0, mem_r_en: 1'b0,
      mem_w_en: 1'b0, b: 1'b0, s: 1'b0, status: 4'hC};

   logic clk = 1'b0;
   logic rst, freeze, flush;
   fields_t id;
   fields_t act;
   logic ex_mem_access;
   logic [CW-1:0] bubble_count, stall_count;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg #(.DATA_W(32), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .freeze           (freeze),
      .flush            (flush),
      .id_valid         (id.valid),
      .id_pc            (id.pc),
      .id_val_rn        (id.val_rn),
      .id_val_rm        (id.val_rm),
      .id_imm           (id.imm),
      .id_shift_operand (id.shift_operand),
      .id_signed_imm_24 (id.signed_imm_24),
      .id_dest          (id.dest),
      .id_src1          (id.src1),
      .id_src2          (id.src2),
      .id_exe_cmd       (id.exe_cmd),
      .id_wb_en         (id.wb_en),
      .id_mem_r_en      (id.mem_r_en),
      .id_mem_w_en      (id.mem_w_en),
      .id_b             (id.b),
      .id_s             (id.s),
      .id_status        (id.status),
      .ex_valid         (act.valid),
      .ex_pc            (act.pc),
      .ex_val_rn        (act.val_rn),
      .ex_val_rm        (act.val_rm),
      .ex_imm           (act.imm),
      .ex_shift_operand (act.shift_operand),
      .ex_signed_imm_24 (act.signed_imm_24),
      .ex_dest          (act.dest),
      .ex_src1          (act.src1),
      .ex_src2          (act.src2),
      .ex_exe_cmd       (act.exe_cmd),
      .ex_wb_en         (act.wb_en),
      .ex_mem_r_en      (act.mem_r_en),
      .ex_mem_w_en      (act.mem_w_en),
      .ex_b             (act.b),
      .ex_s             (act.s),
      .ex_status        (act.status),
      .ex_mem_access    (ex_mem_access),
      .bubble_count     (bubble_count),
      .stall_count      (stall_count)
   );

   task automatic check_fields(input string name, input fields_t exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s fields: got %h want %h", name, act, exp);
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %b want %b", name, got, exp);
   endtask

   task automatic check_cnt(input string name, input logic [CW-1:0] got, input int exp);
      logic [CW-1:0] want;
      want = PERF ? CW'(exp) : '0;
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got %0d want %0d", name, got, want);
   endtask

   vec_t vecs[13];

   initial begin
      // rst, freeze, flush, inputs, expected fields, expected mem_access, bubbles, stalls
      vecs[0]  = '{1'b1, 1'b1, 1'b1, ALL1, ZERO,    1'b0, 0, 0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, A,    A,       1'b1, 0, 0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, B,    A,       1'b1, 0, 1};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, C,    A,       1'b1, 0, 2};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, ALL1, A,       1'b1, 0, 3};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, B,    B,       1'b1, 0, 3};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, C,    C,       1'b0, 0, 3};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, ALL1, ZERO,    1'b0, 1, 3};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, INV,  INV_EXP, 1'b0, 2, 3};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, ALL1, ALL1,    1'b1, 2, 3};
      vecs[10] = '{1'b0, 1'b0, 1'b1, A,    ZERO,    1'b0, 3, 3};
      vecs[11] = '{1'b0, 1'b0, 1'b0, A,    A,       1'b1, 3, 3};
      vecs[12] = '{1'b1, 1'b0, 1'b0, B,    ZERO,    1'b0, 0, 0};

      rst = 1'b0; freeze = 1'b0; flush = 1'b0; id = ZERO;
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) begin
         rst = vecs[i].rst; freeze = vecs[i].freeze; flush = vecs[i].flush; id = vecs[i].in;
         @(posedge clk);
         #1;
         check_fields($sformatf("vec%0d", i), vecs[i].exp);
         check_bit($sformatf("vec%0d mem_access", i), ex_mem_access, vecs[i].exp_ma);
         check_cnt($sformatf("vec%0d bubble_count", i), bubble_count, vecs[i].exp_bub);
         check_cnt($sformatf("vec%0d stall_count", i), stall_count, vecs[i].exp_stl);
      end

      // Load A, then change inputs mid-cycle: outputs must not move before the next edge.
      rst = 1'b0; freeze = 1'b0; flush = 1'b0; id = A;
      @(posedge clk);
      #1;
      id = B;
      #3;
      check_fields("latency hold before edge", A);
      @(posedge clk);
      #1;
      check_fields("latency after edge", B);
      check_cnt("latency bubble_count", bubble_count, 0);

      // 20 consecutive flushes saturate the 4-bit bubble counter.
      flush = 1'b1; id = ALL1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
      end
      #1;
      check_cnt("bubble saturation", bubble_count, 15);
      check_bit("flush ex_valid", act.valid, 1'b0);
      check_cnt("stall under flush", stall_count, 0);

      // 20 consecutive freezes saturate the stall counter and hold the bubble.
      flush = 1'b0; freeze = 1'b1; id = C;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
      end
      #1;
      check_cnt("stall saturation", stall_count, 15);
      check_fields("freeze holds bubble", ZERO);

      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; freeze = 1'b0;
      check_cnt("reset bubble_count", bubble_count, 0);
      check_cnt("reset stall_count", stall_count, 0);
      check_fields("reset fields", ZERO);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
